// File: rtl/core_pkg.sv
// Shared core types: register-file addressing and the bundled writeback request.
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_XLEN    = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic               valid;
        reg_addr_t          addr;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    int unsigned w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (32'(ptr) + k) % N;
            if (!any_gnt && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = IDX_W'(w_idx);
                any_gnt    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin sharing of the register-file write port between writeback sources,
// with a one-entry registered output stage and forwarding hit detection.
module wb_port_arbiter
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_SRC   = 3,
    parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0][XLEN-1:0]   src_data,
    output logic                           wr_en,
    output logic [REG_ADDR_W-1:0]          wr_addr,
    output logic [XLEN-1:0]                wr_data,
    input  logic [REG_ADDR_W-1:0]          rs1_addr,
    input  logic [REG_ADDR_W-1:0]          rs2_addr,
    output logic                           fwd1_hit,
    output logic                           fwd2_hit,
    output logic [XLEN-1:0]                fwd_data,
    output logic [SRC_IDX_W-1:0]           last_grant
);

    logic [SRC_IDX_W-1:0] r_rr_ptr;
    logic                 r_wr_en;
    reg_addr_t            r_wr_addr;
    logic [XLEN-1:0]      r_wr_data;
    logic [SRC_IDX_W-1:0] r_last_grant;

    logic [NUM_SRC-1:0]   w_gnt;
    logic [SRC_IDX_W-1:0] w_gnt_idx;
    logic                 w_any_gnt;

    rr_arbiter #(
        .N     (NUM_SRC),
        .IDX_W (SRC_IDX_W)
    ) u_rr_arbiter (
        .req     (src_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any_gnt (w_any_gnt)
    );

    // Ready is masked by reset so no source sees an accept while rst_n is low.
    assign src_ready = w_gnt & {NUM_SRC{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_last_grant <= '0;
        end else if (w_any_gnt) begin
            r_wr_addr    <= src_addr[w_gnt_idx];
            r_wr_data    <= src_data[w_gnt_idx];
            r_wr_en      <= (src_addr[w_gnt_idx] != '0);
            r_last_grant <= w_gnt_idx;
            r_rr_ptr     <= (w_gnt_idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0
                                                                   : w_gnt_idx + SRC_IDX_W'(1);
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign last_grant = r_last_grant;

    assign fwd1_hit = r_wr_en && (r_wr_addr == rs1_addr);
    assign fwd2_hit = r_wr_en && (r_wr_addr == rs2_addr);
    assign fwd_data = r_wr_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus randomized traffic.
module tb_wb_port_arbiter;
    import core_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 3;
    localparam int IW      = $clog2(NUM_SRC);

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic [NUM_SRC-1:0]                src_valid;
    logic [NUM_SRC-1:0]                src_ready;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0][XLEN-1:0]      src_data;
    logic                              wr_en;
    logic [4:0]                        wr_addr;
    logic [XLEN-1:0]                   wr_data;
    logic [4:0]                        rs1_addr;
    logic [4:0]                        rs2_addr;
    logic                              fwd1_hit;
    logic                              fwd2_hit;
    logic [XLEN-1:0]                   fwd_data;
    logic [IW-1:0]                     last_grant;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .XLEN    (XLEN),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd_data   (fwd_data),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Register array fed by the DUT write port, for end-to-end write visibility.
    logic [XLEN-1:0] tb_rf [NUM_REGS];
    initial for (int r = 0; r < NUM_REGS; r++) tb_rf[r] = '0;
    always @(posedge clk) if (wr_en) tb_rf[wr_addr] <= wr_data;

    // Reference model state.
    typedef struct {
        int unsigned     due;
        logic            en;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        int              g;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    int unsigned     cyc = 0;
    int unsigned     m_ptr = 0;
    int              m_g = -1;
    int unsigned     m_idx;
    logic [4:0]      h_addr = '0;
    logic [XLEN-1:0] h_data = '0;
    int              h_lg = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: predict this cycle's grant from the valids, queue the output-stage result.
    always @(negedge clk) begin
        m_g = -1;
        if (rst_n) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                m_idx = (m_ptr + k) % NUM_SRC;
                if (m_g < 0 && src_valid[m_idx]) m_g = m_idx;
            end
            chk("src_ready", 64'(src_ready), (m_g < 0) ? 64'd0 : (64'd1 << m_g));
            if (m_g >= 0) begin
                sb.push_back('{cyc + 1, src_addr[m_g] != 5'd0, src_addr[m_g], src_data[m_g], m_g});
                m_ptr = (m_g + 1) % NUM_SRC;
            end
        end
    end

    // Monitor: compare the output stage against the queued expectation due this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                h_addr = e.addr;
                h_data = e.data;
                h_lg   = e.g;
                chk("wr_en", 64'(wr_en), 64'(e.en));
                chk("fwd1_hit", 64'(fwd1_hit), 64'(e.en && e.addr == rs1_addr));
                chk("fwd2_hit", 64'(fwd2_hit), 64'(e.en && e.addr == rs2_addr));
            end else begin
                chk("wr_en_idle", 64'(wr_en), 64'd0);
                chk("fwd_idle", 64'({fwd1_hit, fwd2_hit}), 64'd0);
            end
            chk("wr_addr", 64'(wr_addr), 64'(h_addr));
            chk("wr_data", 64'(wr_data), 64'(h_data));
            chk("fwd_data", 64'(fwd_data), 64'(h_data));
            chk("last_grant", 64'(last_grant), 64'(h_lg));
        end
    end

    task automatic model_reset();
        sb.delete();
        m_ptr  = 0;
        h_addr = '0;
        h_data = '0;
        h_lg   = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;

        // Reset held for 3 cycles, outputs forced to zero.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_last_grant", 64'(last_grant), 64'd0);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Single source, 1-cycle write latency.
        #1;
        src_valid = 3'b001;
        src_addr[0] = 5'd5;
        src_data[0] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(src_ready), 64'b001);
        @(posedge clk);
        #1;
        src_valid = '0;
        chk("single_wr_en", 64'(wr_en), 64'd1);
        chk("single_wr_addr", 64'(wr_addr), 64'd5);
        chk("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("single_rf_x5", 64'(tb_rf[5]), 64'hDEADBEEF);

        // Three-way contention from pointer 0.
        do_reset();
        src_valid = 3'b111;
        src_addr[0] = 5'd1; src_addr[1] = 5'd2; src_addr[2] = 5'd3;
        src_data[0] = 32'h11; src_data[1] = 32'h22; src_data[2] = 32'h33;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("contention_grant", 64'(src_ready), 64'd1 << (c % 3));
            if (c > 0) chk("contention_wr_addr", 64'(wr_addr), 64'((c - 1) % 3 + 1));
            @(posedge clk);
            #1;
        end
        src_valid = '0;
        @(posedge clk);

        // x0 write: accepted but never written.
        #1;
        src_valid = 3'b010;
        src_addr[1] = 5'd0;
        src_data[1] = 32'h1234;
        rs1_addr = 5'd0;
        #1;
        chk("x0_ready", 64'(src_ready), 64'b010);
        @(posedge clk);
        #1;
        src_valid = '0;
        chk("x0_wr_en", 64'(wr_en), 64'd0);
        chk("x0_fwd1", 64'(fwd1_hit), 64'd0);
        @(posedge clk);
        #1;
        chk("x0_rf", 64'(tb_rf[0]), 64'd0);

        // Forwarding from the output stage.
        src_valid = 3'b100;
        src_addr[2] = 5'd7;
        src_data[2] = 32'hA5A5A5A5;
        rs1_addr = 5'd7;
        rs2_addr = 5'd8;
        @(posedge clk);
        #1;
        src_valid = '0;
        chk("fwd_hit1", 64'(fwd1_hit), 64'd1);
        chk("fwd_hit2", 64'(fwd2_hit), 64'd0);
        chk("fwd_data_val", 64'(fwd_data), 64'hA5A5A5A5);
        @(posedge clk);
        #1;
        chk("fwd_after", 64'({fwd1_hit, fwd2_hit}), 64'd0);

        // Randomized traffic; sources hold requests until accepted, occasionally withdraw.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!src_valid[i] || m_g == i) begin
                    src_valid[i] = ($urandom_range(0, 99) < 55);
                    src_addr[i]  = 5'($urandom_range(0, 7));
                    src_data[i]  = $urandom;
                end else if ($urandom_range(0, 99) < 5) begin
                    src_valid[i] = 1'b0;
                end
            end
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
        end

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #1;
        src_valid = 3'b111;
        src_addr[0] = 5'd9; src_addr[1] = 5'd10; src_addr[2] = 5'd11;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_wr_en", 64'(wr_en), 64'd0);
        chk("async_rst_ready", 64'(src_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 64'(src_ready), 64'b001);
        repeat (5) @(posedge clk);
        #1;
        src_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
